pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the ID-stage branch/jump resolution: holds the fetch PC, advances it sequentially, and applies taken-branch/jump redirects (bne, j, jal, jr) reported by the comparator.
- Generates the IF/ID flush for the wrong-path instruction, queues a redirect while instruction memory is not ready, and keeps redirect statistics.
- Sits between the hazard unit, the ID-stage comparator and the instruction memory / IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DELAY_SLOT, 0, 1 = instruction after a branch executes (no flush); 0 = it is flushed.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard unit freeze of PC and IF/ID; ID decision not final while high.
- ImemReady  in  1  instruction memory can accept a fetch this cycle.
- BranchValid  in  1  ID instruction is a control instruction (comparator Branch).
- BranchTaken  in  1  ID control instruction is taken (comparator Output).
- BranchTarget  in  32  resolved target address from ID.
- PC  out  32  current fetch address (registered).
- PCPlus4  out  32  PC + 4, mod 2^32 (combinational, for jal link).
- FetchValid  out  1  registered; PC is a live fetch.
- FlushIFID  out  1  combinational; zero the IF/ID register at this edge.
- Pending  out  1  high in state PENDING.
- MisalignErr  out  1  sticky; a target with [1:0] != 0 was applied.
- TakenCount  out  16  redirects applied, saturating.
- BranchCount  out  16  accepted control instructions (taken or not), saturating.

Behaviour:
- Reset (asynchronous, any state): PC=RESET_PC, FetchValid=0, state RUN, PendTarget=0, MisalignErr=0, both counters=0. FlushIFID and Pending are 0 during reset.
- First rising edge after reset deasserts: FetchValid goes 1 and PC holds RESET_PC. PC advances from the following edge.
- Definitions:
  - adv = ~Stall & ImemReady.
  - acc = BranchValid & ~Stall (decision accepted).
  - req = acc & BranchTaken.
- State RUN:
  - req & ImemReady: PC <= {BranchTarget[31:2],2'b00}. FlushIFID = ~DELAY_SLOT this cycle. Stay RUN.
  - req & ~ImemReady: PendTarget <= BranchTarget. PC holds. Go to PENDING. FlushIFID = 0.
  - ~req & adv: PC <= PC+4, wrapping 32'hFFFF_FFFC -> 0.
  - Otherwise PC holds.
- State PENDING:
  - BranchValid/BranchTaken are ignored (the ID stage holds only wrong-path or bubble).
  - Stall is ignored; the redirect is already committed.
  - ImemReady=1: PC <= {PendTarget[31:2],2'b00}, FlushIFID = ~DELAY_SLOT, go to RUN.
  - ImemReady=0: hold.
- MisalignErr sets on the edge any target is applied with low bits != 2'b00. It clears only on Reset.
- Counters:
  - BranchCount increments on acc in RUN.
  - TakenCount increments on each applied redirect (RUN immediate or PENDING release), not on queuing.
  - Both hold at 16'hFFFF.
- Stall high with BranchValid=1 in RUN: no redirect, no count, PC holds.
- Reset during PENDING: the pending redirect is discarded.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, then release, Stall=0, ImemReady=1 -> PC shows 40, 40, 44, 48 on successive edges; FetchValid=1 from the first edge.
- At PC=32'h0000_0010, BranchValid=1, BranchTaken=1, BranchTarget=32'h0000_0100, DELAY_SLOT=0 -> FlushIFID=1 that cycle, next PC=100, TakenCount=1, BranchCount=1.
- bne not taken (BranchValid=1, BranchTaken=0) at PC=20 -> PC=24, FlushIFID=0, BranchCount=1, TakenCount=0. The same request with Stall=1 -> PC held, counts unchanged.
- Taken request to target 32'h0000_0200 with ImemReady=0 for 3 cycles:
  - Pending=1 and PC held for those 3 cycles.
  - Taken request to 300 during that window is ignored.
  - When ImemReady rises: PC=200, FlushIFID pulse, Pending=0, TakenCount=1.
- Target 32'h0000_0103 -> PC=32'h0000_0100, MisalignErr=1 and it stays set. PC=32'hFFFF_FFFC with adv -> PC=0, and PCPlus4 at FFFF_FFFC reads 0.
- Reset asserted mid-PENDING -> PC=RESET_PC immediately with no clock edge, Pending=0; after release there is no redirect to the queued target.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with ID-stage branch/jump redirect, a one-entry redirect
// queue for when instruction memory stalls, and redirect statistics.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        ImemReady,
  input  logic        BranchValid,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic        FlushIFID,
  output logic        Pending,
  output logic        MisalignErr,
  output logic [15:0] TakenCount,
  output logic [15:0] BranchCount
);

  typedef enum logic {RUN, PENDING} state_t;

  state_t      state_q;
  logic [31:0] pc_q, pend_q;
  logic        fv_q, mis_q;
  logic [15:0] tcnt_q, bcnt_q;

  logic        in_run, acc, req, adv, apply;
  logic [31:0] apply_tgt;

  // Nothing is accepted until the first post-reset edge has made the PC live.
  assign in_run    = (state_q == RUN);
  assign acc       = fv_q & in_run & BranchValid & ~Stall;
  assign req       = acc & BranchTaken;
  assign adv       = fv_q & ~Stall & ImemReady;
  assign apply     = in_run ? (req & ImemReady) : ImemReady;
  assign apply_tgt = in_run ? BranchTarget : pend_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      fv_q <= 1'b1;
      if (apply) begin
        pc_q    <= {apply_tgt[31:2], 2'b00};
        state_q <= RUN;
        if (apply_tgt[1:0] != 2'b00) mis_q <= 1'b1;
        if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
      end else if (req) begin
        pend_q  <= BranchTarget;
        state_q <= PENDING;
      end else if (in_run && adv) begin
        pc_q <= pc_q + 32'd4;
      end
      if (acc && bcnt_q != 16'hFFFF) bcnt_q <= bcnt_q + 16'd1;
    end
  end

  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign FetchValid  = fv_q;
  assign FlushIFID   = apply & ~DELAY_SLOT & ~Reset;
  assign Pending     = ~in_run & ~Reset;
  assign MisalignErr = mis_q;
  assign TakenCount  = tcnt_q;
  assign BranchCount = bcnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: sequential fetch, taken/not-taken,
// stall gating, queued redirect, misalign/wrap and reset during PENDING.
module tb_pc_redirect_unit;

  logic        Clk, Reset, Stall, ImemReady, BranchValid, BranchTaken;
  logic [31:0] BranchTarget, PC, PCPlus4;
  logic        FetchValid, FlushIFID, Pending, MisalignErr;
  logic [15:0] TakenCount, BranchCount;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(.RESET_PC(32'h0000_0040), .DELAY_SLOT(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .ImemReady(ImemReady),
    .BranchValid(BranchValid), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .PC(PC), .PCPlus4(PCPlus4),
    .FetchValid(FetchValid), .FlushIFID(FlushIFID), .Pending(Pending),
    .MisalignErr(MisalignErr), .TakenCount(TakenCount),
    .BranchCount(BranchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 0; ImemReady = 1; BranchValid = 0; BranchTaken = 0;
    BranchTarget = 32'h0;
  endtask

  // Reset pulse between edges, then one edge so the PC is live at RESET_PC.
  task automatic do_reset();
    idle_inputs();
    @(negedge Clk);
    Reset = 1;
    #2;
    Reset = 0;
    tick();
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    BranchValid = 1; BranchTaken = 1; BranchTarget = tgt;
    tick();
    BranchValid = 0; BranchTaken = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    #3;
    checks++;
    if (PC !== 32'h40 || FetchValid !== 1'b0 || FlushIFID !== 1'b0 || Pending !== 1'b0 ||
        MisalignErr !== 1'b0 || TakenCount !== 16'd0 || BranchCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: PC=%h FV=%b FL=%b PD=%b MIS=%b TC=%0d BC=%0d expected PC=40 rest 0",
               PC, FetchValid, FlushIFID, Pending, MisalignErr, TakenCount, BranchCount);
    end
    @(negedge Clk);
    Reset = 0;
    tick();
    checks++;
    if (PC !== 32'h40 || FetchValid !== 1'b1) begin
      errors++; $display("FAIL first_edge: PC=%h FV=%b expected 40/1", PC, FetchValid);
    end
    tick();
    checks++;
    if (PC !== 32'h44) begin errors++; $display("FAIL seq_44: PC=%h expected 44", PC); end
    tick();
    checks++;
    if (PC !== 32'h48) begin errors++; $display("FAIL seq_48: PC=%h expected 48", PC); end
  endtask

  task automatic test_taken();
    do_reset();
    redirect_to(32'h10);
    checks++;
    if (PC !== 32'h10) begin errors++; $display("FAIL jump_to_10: PC=%h expected 10", PC); end
    BranchValid = 1; BranchTaken = 1; BranchTarget = 32'h100;
    #1;
    checks++;
    if (FlushIFID !== 1'b1) begin errors++; $display("FAIL taken_flush: got %b expected 1", FlushIFID); end
    tick();
    BranchValid = 0; BranchTaken = 0;
    checks++;
    if (PC !== 32'h100 || TakenCount !== 16'd2 || BranchCount !== 16'd2) begin
      errors++;
      $display("FAIL taken_apply: PC=%h TC=%0d BC=%0d expected 100/2/2", PC, TakenCount, BranchCount);
    end
    #1;
    checks++;
    if (FlushIFID !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", FlushIFID); end
  endtask

  task automatic test_not_taken_and_stall();
    do_reset();
    redirect_to(32'h20);
    BranchValid = 1; BranchTaken = 0; BranchTarget = 32'h500;
    #1;
    checks++;
    if (FlushIFID !== 1'b0) begin errors++; $display("FAIL nt_flush: got %b expected 0", FlushIFID); end
    tick();
    checks++;
    if (PC !== 32'h24 || BranchCount !== 16'd2 || TakenCount !== 16'd1) begin
      errors++;
      $display("FAIL not_taken: PC=%h BC=%0d TC=%0d expected 24/2/1", PC, BranchCount, TakenCount);
    end
    Stall = 1; BranchTaken = 1;
    #1;
    checks++;
    if (FlushIFID !== 1'b0) begin errors++; $display("FAIL stall_flush: got %b expected 0", FlushIFID); end
    tick();
    checks++;
    if (PC !== 32'h24 || BranchCount !== 16'd2 || TakenCount !== 16'd1) begin
      errors++;
      $display("FAIL stall_hold: PC=%h BC=%0d TC=%0d expected 24/2/1", PC, BranchCount, TakenCount);
    end
    idle_inputs();
  endtask

  task automatic test_pending();
    do_reset();
    ImemReady = 0; BranchValid = 1; BranchTaken = 1; BranchTarget = 32'h200;
    #1;
    checks++;
    if (FlushIFID !== 1'b0) begin errors++; $display("FAIL queue_flush: got %b expected 0", FlushIFID); end
    for (int i = 0; i < 3; i++) begin
      tick();
      BranchTarget = 32'h300;
      checks++;
      if (Pending !== 1'b1 || PC !== 32'h40 || TakenCount !== 16'd0) begin
        errors++;
        $display("FAIL pend_hold[%0d]: PD=%b PC=%h TC=%0d expected 1/40/0", i, Pending, PC, TakenCount);
      end
    end
    ImemReady = 1;
    #1;
    checks++;
    if (FlushIFID !== 1'b1) begin errors++; $display("FAIL release_flush: got %b expected 1", FlushIFID); end
    tick();
    BranchValid = 0; BranchTaken = 0;
    checks++;
    if (PC !== 32'h200 || Pending !== 1'b0 || TakenCount !== 16'd1 || BranchCount !== 16'd1) begin
      errors++;
      $display("FAIL release: PC=%h PD=%b TC=%0d BC=%0d expected 200/0/1/1",
               PC, Pending, TakenCount, BranchCount);
    end
  endtask

  task automatic test_misalign_wrap();
    do_reset();
    checks++;
    if (MisalignErr !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", MisalignErr); end
    redirect_to(32'h103);
    checks++;
    if (PC !== 32'h100 || MisalignErr !== 1'b1) begin
      errors++; $display("FAIL misalign: PC=%h MIS=%b expected 100/1", PC, MisalignErr);
    end
    redirect_to(32'hFFFF_FFFC);
    checks++;
    if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0 || MisalignErr !== 1'b1) begin
      errors++;
      $display("FAIL wrap_setup: PC=%h P4=%h MIS=%b expected FFFFFFFC/0/1", PC, PCPlus4, MisalignErr);
    end
    tick();
    checks++;
    if (PC !== 32'h0 || MisalignErr !== 1'b1) begin
      errors++; $display("FAIL wrap: PC=%h MIS=%b expected 0/1", PC, MisalignErr);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    ImemReady = 0; BranchValid = 1; BranchTaken = 1; BranchTarget = 32'h200;
    tick();
    BranchValid = 0; BranchTaken = 0;
    checks++;
    if (Pending !== 1'b1) begin errors++; $display("FAIL rp_enter: PD=%b expected 1", Pending); end
    redirect_to(32'h0);
    ImemReady = 0;
    #2;
    Reset = 1;
    #1;
    checks++;
    if (PC !== 32'h40 || Pending !== 1'b0 || FetchValid !== 1'b0 || FlushIFID !== 1'b0 ||
        BranchCount !== 16'd0) begin
      errors++;
      $display("FAIL rp_async: PC=%h PD=%b FV=%b FL=%b BC=%0d expected 40/0/0/0/0",
               PC, Pending, FetchValid, FlushIFID, BranchCount);
    end
    ImemReady = 1;
    #1;
    checks++;
    if (FlushIFID !== 1'b0) begin errors++; $display("FAIL rp_flush_in_reset: got %b expected 0", FlushIFID); end
    @(negedge Clk);
    Reset = 0;
    tick();
    checks++;
    if (PC !== 32'h40 || FetchValid !== 1'b1) begin
      errors++; $display("FAIL rp_restart: PC=%h FV=%b expected 40/1", PC, FetchValid);
    end
    tick();
    checks++;
    if (PC !== 32'h44 || TakenCount !== 16'd0) begin
      errors++; $display("FAIL rp_discard: PC=%h TC=%0d expected 44/0", PC, TakenCount);
    end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_not_taken_and_stall();
    test_pending();
    test_misalign_wrap();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
